uart_cmd_ctrl: RTL and testbench

Command sequencer that consumes the byte stream from the UART receiver (one-cycle data/data_valid strobes) and parses fixed 5-byte frames into register-bus writes and reads. It sequences the register bus and queues a one-byte response (ACK, NAK or read data) to a UART transmitter over a valid/ready handshake. It sits between the UART receive path and the design's control-register file.

---
 rtl/uart_cmd_ctrl.sv | 142 ++++++++++++++
 tb/tb_uart_cmd_ctrl.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_ctrl.sv
// UART command sequencer: parses SYNC/CMD/ADDR/DATA/CHK frames into register writes/reads
// and queues a one-byte ACK/NAK/read-data response. Define UART_CMD_TIMEOUT_EN for the inter-byte timeout.
module uart_cmd_ctrl #(
    parameter logic [7:0] SYNC_BYTE    = 8'hA5,
    parameter int         TIMEOUT_CLKS = 12000,
    parameter logic [7:0] CMD_WR       = 8'h57,
    parameter logic [7:0] CMD_RD       = 8'h52
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       wr_en,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       rd_en,
    output logic [7:0] rd_addr,
    input  logic [7:0] rd_data,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       busy,
    output logic [7:0] err_count,
    output logic       overrun
);

    localparam logic [7:0] RESP_ACK = 8'h06;
    localparam logic [7:0] RESP_NAK = 8'h15;

    typedef enum logic [2:0] {HUNT, CMD, ADDR, DATA, CHK, EXEC, RDWAIT, RESP} state_t;

    state_t     state;
    logic [7:0] cmd, addr, data, chk, resp;

`ifdef UART_CMD_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CLKS + 1);
    logic [TW-1:0] tmo_cnt;
`endif

    assign busy    = (state != HUNT);
    assign tx_data = resp;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= HUNT;
            cmd       <= '0;
            addr      <= '0;
            data      <= '0;
            chk       <= '0;
            resp      <= '0;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            rd_en     <= 1'b0;
            rd_addr   <= '0;
            tx_valid  <= 1'b0;
            err_count <= '0;
            overrun   <= 1'b0;
`ifdef UART_CMD_TIMEOUT_EN
            tmo_cnt   <= '0;
`endif
        end else begin
            wr_en <= 1'b0;
            rd_en <= 1'b0;
            // Bytes arriving while the bus/response side is busy are lost.
            if (rx_valid && (state == EXEC || state == RDWAIT || state == RESP))
                overrun <= 1'b1;
            case (state)
                HUNT: if (rx_valid && rx_data == SYNC_BYTE) begin
                    chk   <= '0;
                    state <= CMD;
                end
                CMD: if (rx_valid) begin
                    cmd   <= rx_data;
                    chk   <= rx_data;
                    state <= ADDR;
                end
                ADDR: if (rx_valid) begin
                    addr  <= rx_data;
                    chk   <= chk ^ rx_data;
                    state <= DATA;
                end
                DATA: if (rx_valid) begin
                    data  <= rx_data;
                    chk   <= chk ^ rx_data;
                    state <= CHK;
                end
                CHK: if (rx_valid) begin
                    if (rx_data == chk && (cmd == CMD_WR || cmd == CMD_RD)) begin
                        // Strobes are launched here so they are high during EXEC.
                        if (cmd == CMD_WR) begin
                            wr_en   <= 1'b1;
                            wr_addr <= addr;
                            wr_data <= data;
                        end else begin
                            rd_en   <= 1'b1;
                            rd_addr <= addr;
                        end
                        state <= EXEC;
                    end else begin
                        resp      <= RESP_NAK;
                        tx_valid  <= 1'b1;
                        err_count <= (err_count == 8'hFF) ? err_count : err_count + 8'd1;
                        state     <= RESP;
                    end
                end
                EXEC: begin
                    if (cmd == CMD_WR) begin
                        resp     <= RESP_ACK;
                        tx_valid <= 1'b1;
                        state    <= RESP;
                    end else begin
                        state <= RDWAIT;
                    end
                end
                RDWAIT: begin
                    resp     <= rd_data;
                    tx_valid <= 1'b1;
                    state    <= RESP;
                end
                RESP: if (tx_ready) begin
                    tx_valid <= 1'b0;
                    state    <= HUNT;
                end
                default: state <= HUNT;
            endcase
`ifdef UART_CMD_TIMEOUT_EN
            // A byte in the expiry cycle wins; the case above has already consumed it.
            if (rx_valid || !(state == CMD || state == ADDR || state == DATA || state == CHK)) begin
                tmo_cnt <= '0;
            end else if (tmo_cnt == TW'(TIMEOUT_CLKS - 1)) begin
                tmo_cnt   <= '0;
                err_count <= (err_count == 8'hFF) ? err_count : err_count + 8'd1;
                state     <= HUNT;
            end else begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Bench for uart_cmd_ctrl: frame vector table plus scoreboard queues for bus strobes and responses.
module tb_uart_cmd_ctrl;

    localparam int TMO = 12000;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] rx_data = '0;
    logic       rx_valid = 1'b0;
    logic       wr_en, rd_en, tx_valid, busy, overrun;
    logic [7:0] wr_addr, wr_data, rd_addr, tx_data, err_count;
    logic [7:0] rd_data = '0;
    logic       tx_ready = 1'b1;

    int checks = 0;
    int errors = 0;

    uart_cmd_ctrl dut (
        .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .busy(busy), .err_count(err_count), .overrun(overrun)
    );

    always #5 clk = ~clk;

    // Register file stand-in: value depends on address, returned the cycle after rd_en.
    always @(posedge clk) if (rd_en) rd_data <= rd_addr ^ 8'hBE;

    typedef struct {
        logic [39:0] frame;
        logic [7:0]  resp;
        logic        is_wr;
        logic        is_rd;
        logic [7:0]  addr;
        logic [7:0]  data;
        logic [7:0]  err;
    } vec_t;

    typedef struct packed {
        logic       is_wr;
        logic [7:0] addr;
        logic [7:0] data;
    } bus_t;

    bus_t       bus_q[$];
    logic [7:0] resp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: strobes and accepted responses are compared as they appear.
    always @(negedge clk) if (rst_n) begin
        bus_t b;
        if (wr_en && rd_en) check("wr_rd_exclusive", 1, 0);
        if (wr_en || rd_en) begin
            if (bus_q.size() == 0) check("unexpected_strobe", {wr_en, rd_en, wr_addr, rd_addr}, 0);
            else begin
                b = bus_q.pop_front();
                if (b.is_wr) check("wr_strobe", {wr_en, rd_en, wr_addr, wr_data}, {2'b10, b.addr, b.data});
                else check("rd_strobe", {wr_en, rd_en, rd_addr}, {2'b01, b.addr});
            end
        end
        if (tx_valid && tx_ready) begin
            if (resp_q.size() == 0) check("unexpected_resp", {1'b1, tx_data}, 0);
            else check("tx_data", tx_data, resp_q.pop_front());
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #1;
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk); #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [39:0] f);
        for (int i = 0; i < 5; i++) send_byte(f[39-8*i -: 8]);
    endtask

    task automatic expect_frame(input vec_t v);
        if (v.is_wr || v.is_rd) bus_q.push_back({v.is_wr, v.addr, v.data});
        resp_q.push_back(v.resp);
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while ((resp_q.size() != 0 || busy) && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        check({name, "_done"}, (n >= 300), 0);
        check({name, "_bus_q_empty"}, bus_q.size(), 0);
    endtask

    task automatic check_reset_outs(input string name);
        check(name, {wr_en, wr_addr, wr_data, rd_en, rd_addr, tx_data, tx_valid, busy, err_count, overrun}, 0);
    endtask

    vec_t vecs[7];
    logic [7:0] err_snap;

    initial begin
        vecs[0] = '{40'hA5_57_10_3C_7B, 8'h06, 1'b1, 1'b0, 8'h10, 8'h3C, 8'd0};
        vecs[1] = '{40'hA5_52_20_00_72, 8'h9E, 1'b0, 1'b1, 8'h20, 8'h00, 8'd0};
        vecs[2] = '{40'hA5_57_10_3C_00, 8'h15, 1'b0, 1'b0, 8'h00, 8'h00, 8'd1};
        vecs[3] = '{40'hA5_58_01_02_5B, 8'h15, 1'b0, 1'b0, 8'h00, 8'h00, 8'd2};
        vecs[4] = '{40'hA5_57_FF_00_A8, 8'h06, 1'b1, 1'b0, 8'hFF, 8'h00, 8'd2};
        vecs[5] = '{40'hA5_52_FF_11_BC, 8'h41, 1'b0, 1'b1, 8'hFF, 8'h11, 8'd2};
        vecs[6] = '{40'hA5_57_A5_A5_57, 8'h06, 1'b1, 1'b0, 8'hA5, 8'hA5, 8'd2};

        repeat (3) @(posedge clk);
        #1 check_reset_outs("reset_state");
        rst_n = 1'b1;

        // Table-driven frames
        for (int i = 0; i < 7; i++) begin
            expect_frame(vecs[i]);
            send_frame(vecs[i].frame);
            wait_done($sformatf("vec%0d", i));
            check($sformatf("vec%0d_err_count", i), err_count, vecs[i].err);
            check($sformatf("vec%0d_overrun", i), overrun, 0);
        end

        // Junk in HUNT is silently ignored
        send_byte(8'h00); send_byte(8'h41); send_byte(8'h57);
        check("junk_busy_ovr_err", {busy, overrun, err_count}, {2'b00, 8'd2});

        // Write latency: wr_en the cycle after CHK, tx_valid the cycle after that
        bus_q.push_back({1'b1, 8'h10, 8'h3C});
        resp_q.push_back(8'h06);
        for (int i = 0; i < 4; i++) send_byte(vecs[0].frame[39-8*i -: 8]);
        @(posedge clk); #1 rx_data = 8'h7B; rx_valid = 1'b1;
        @(posedge clk); #1 rx_valid = 1'b0;
        check("wr_lat_exec", {wr_en, tx_valid}, 2'b10);
        @(posedge clk); #1 check("wr_lat_resp", {wr_en, tx_valid}, 2'b01);
        wait_done("wr_lat");

        // Read latency: tx_valid three cycles after CHK
        bus_q.push_back({1'b0, 8'h20, 8'h00});
        resp_q.push_back(8'h9E);
        for (int i = 0; i < 4; i++) send_byte(vecs[1].frame[39-8*i -: 8]);
        @(posedge clk); #1 rx_data = 8'h72; rx_valid = 1'b1;
        @(posedge clk); #1 rx_valid = 1'b0;
        check("rd_lat_exec", {rd_en, tx_valid}, 2'b10);
        @(posedge clk); #1 check("rd_lat_wait", {rd_en, tx_valid}, 2'b00);
        @(posedge clk); #1 check("rd_lat_resp", {rd_en, tx_valid}, 2'b01);
        wait_done("rd_lat");

        // Backpressure with a dropped byte in RESP
        tx_ready = 1'b0;
        expect_frame(vecs[0]);
        send_frame(vecs[0].frame);
        repeat (10) @(posedge clk);
        send_byte(8'h41);
        repeat (88) @(posedge clk);
        #1 check("bp_hold", {tx_valid, tx_data, overrun, busy}, {1'b1, 8'h06, 2'b11});
        tx_ready = 1'b1;
        @(posedge clk); #1 check("bp_release", {tx_valid, busy, overrun}, 3'b001);
        check("bp_resp_popped", resp_q.size(), 0);

        // Reset mid-frame
        send_byte(8'hA5); send_byte(8'h57); send_byte(8'h10);
        @(posedge clk); #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 check_reset_outs("midframe_reset");
        rst_n = 1'b1;
        expect_frame(vecs[0]);
        send_frame(vecs[0].frame);
        wait_done("post_reset");
        check("post_reset_err", err_count, 0);

`ifdef UART_CMD_TIMEOUT_EN
        // Inter-byte timeout: back to HUNT, one error, no response
        err_snap = err_count;
        send_byte(8'hA5); send_byte(8'h57);
        repeat (TMO + 2) @(posedge clk);
        #1 check("tmo_state", {busy, tx_valid, err_count}, {2'b00, err_snap + 8'd1});
        expect_frame(vecs[0]);
        send_frame(vecs[0].frame);
        wait_done("tmo_recover");
`endif

        // Saturate err_count at 255
        begin
            int n = 0;
            while (err_count != 8'hFF && n < 300) begin
                resp_q.push_back(8'h15);
                send_frame(vecs[2].frame);
                wait_done("sat_fill");
                n++;
            end
            check("sat_reached", err_count, 8'hFF);
        end
        resp_q.push_back(8'h15);
        send_frame(vecs[2].frame);
        wait_done("sat_hold");
        check("sat_hold_err", err_count, 8'hFF);

        err_snap = err_count;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
